// File: rtl/uart_rx_timing_pkg.sv
// Shared UART RX timing constants (prescale ratios, counter widths) and the 3-input majority helper.
package uart_rx_timing_pkg;

  localparam int PRESCALE_W_DEF = 6;
  localparam int EDGE_W_DEF     = 5;
  localparam int BIT_W_DEF      = 4;

  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_X8       = 6'd8;
  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_X16      = 6'd16;
  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_X32      = 6'd32;
  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_DEFAULT  = PRESCALE_X8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Registered 3-sample majority vote; produces the recovered bit and a one-cycle valid pulse.
module uart_rx_majority3
  import uart_rx_timing_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic window_en,
  input  logic cap0,
  input  logic cap1,
  input  logic cap2,
  output logic sampled_bit,
  output logic samp_valid
);

  logic s0;
  logic s1;
  logic have0;
  logic have1;

  // The third sample goes straight into the vote, so only s0/s1 are stored;
  // have0/have1 track an uninterrupted window so a dropped window never votes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      have0       <= 1'b0;
      have1       <= 1'b0;
      sampled_bit <= 1'b1;
      samp_valid  <= 1'b0;
    end else begin
      samp_valid <= 1'b0;
      if (!window_en) begin
        have0 <= 1'b0;
        have1 <= 1'b0;
      end else begin
        if (cap0) begin
          s0    <= sample;
          have0 <= 1'b1;
          have1 <= 1'b0;
        end
        if (cap1) begin
          s1    <= sample;
          have1 <= have0;
        end
        if (cap2) begin
          if (have1) begin
            sampled_bit <= majority3(s0, s1, sample);
            samp_valid  <= 1'b1;
          end
          have0 <= 1'b0;
          have1 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_timing.sv
// UART RX oversampling counters, prescale latch and mid-bit majority sampling.
// Define UART_RX_SYNC_EN to add a 2-flop synchroniser on rx_in ahead of the sampler.
module uart_rx_timing
  import uart_rx_timing_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int EDGE_W     = EDGE_W_DEF,
  parameter int BIT_W      = BIT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  input  logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  sampled_bit,
  output logic                  samp_valid
);

  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescale_legal;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] edge_ext;
  logic                  rx_s;
  logic                  window_en;
  logic                  cap0;
  logic                  cap1;
  logic                  cap2;

`ifdef UART_RX_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rx_in;
      sync_q2 <= sync_q1;
    end
  end

  assign rx_s = sync_q2;
`else
  assign rx_s = rx_in;
`endif

  // Unsupported ratios fall back to x8 so the counters always wrap on a sane boundary.
  always_comb begin
    prescale_legal = PRESCALE_W'(PRESCALE_DEFAULT);
    case (prescale)
      PRESCALE_W'(PRESCALE_X8),
      PRESCALE_W'(PRESCALE_X16),
      PRESCALE_W'(PRESCALE_X32): prescale_legal = prescale;
      default:                   prescale_legal = PRESCALE_W'(PRESCALE_DEFAULT);
    endcase
  end

  // Ratio is only followed between frames; once enabled it is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= PRESCALE_W'(PRESCALE_DEFAULT);
    end else if (!enable) begin
      prescale_q <= prescale_legal;
    end
  end

  assign edge_ext  = PRESCALE_W'(edge_cnt);
  assign half      = prescale_q >> 1;
  assign last_edge = prescale_q - PRESCALE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_ext == last_edge) begin
      edge_cnt <= '0;
      if (bit_cnt != '1) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  assign window_en = enable & dat_samp_en;
  assign cap0      = window_en && (edge_ext == half - PRESCALE_W'(1));
  assign cap1      = window_en && (edge_ext == half);
  assign cap2      = window_en && (edge_ext == half + PRESCALE_W'(1));

  uart_rx_majority3 u_vote (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (rx_s),
    .window_en   (window_en),
    .cap0        (cap0),
    .cap1        (cap1),
    .cap2        (cap2),
    .sampled_bit (sampled_bit),
    .samp_valid  (samp_valid)
  );

endmodule

// File: tb/tb_uart_rx_timing.sv
// Directed bench for uart_rx_timing: counters, prescale latching, majority vote and reset.
module tb_uart_rx_timing;

`ifdef UART_RX_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       enable;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  int asserts_run;
  int fail_count;

  uart_rx_timing dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .enable      (enable),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .samp_valid  (samp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic dse, input logic rx, input logic [5:0] ps);
    enable      = en;
    dat_samp_en = dse;
    rx_in       = rx;
    prescale    = ps;
  endtask

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    asserts_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  initial begin
    int j;
    int e;
    asserts_run = 0;
    fail_count  = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
    #12;
    checkOutput("rst_edge", 0, 32'(edge_cnt), 32'd0);
    checkOutput("rst_bit", 0, 32'(bit_cnt), 32'd0);
    checkOutput("rst_sampled", 0, 32'(sampled_bit), 32'd1);
    checkOutput("rst_valid", 0, 32'(samp_valid), 32'd0);
    #1 rst_n = 1'b1;
    step();

    $display("[TB] x8 counter sweep and bit_cnt saturation");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
    step();
    enable = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step();
      checkOutput("x8_edge", k, 32'(edge_cnt), 32'(k % 8));
      checkOutput("x8_bit", k, 32'(bit_cnt), 32'(k / 8));
    end
    for (int k = 81; k <= 136; k++) step();
    checkOutput("sat_bit", 136, 32'(bit_cnt), 32'd15);
    checkOutput("sat_edge", 136, 32'(edge_cnt), 32'd0);

    $display("[TB] x16 vote on samples 0,0,1");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd16);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd16);
    for (int k = 0; k < 16; k++) begin
      j = k + LAG;
      rx_in = (j == 7 || j == 8) ? 1'b0 : 1'b1;
      step();
      checkOutput("x16_edge", k, 32'(edge_cnt), 32'((k + 1) % 16));
      checkOutput("x16_valid", k, 32'(samp_valid), ((k + 1) == 10) ? 32'd1 : 32'd0);
      if ((k + 1) == 10) checkOutput("x16_sampled", k, 32'(sampled_bit), 32'd0);
    end

    $display("[TB] async reset mid-frame");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
    step();
    enable = 1'b1;
    repeat (29) step();
    checkOutput("pre_rst_edge", 29, 32'(edge_cnt), 32'd5);
    checkOutput("pre_rst_bit", 29, 32'(bit_cnt), 32'd3);
    checkOutput("pre_rst_sampled", 29, 32'(sampled_bit), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_edge", 0, 32'(edge_cnt), 32'd0);
    checkOutput("mid_rst_bit", 0, 32'(bit_cnt), 32'd0);
    checkOutput("mid_rst_sampled", 0, 32'(sampled_bit), 32'd1);
    checkOutput("mid_rst_valid", 0, 32'(samp_valid), 32'd0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] x8 zero bit then single-edge glitch");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd8);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd8);
    for (int k = 0; k < 16; k++) begin
      j = k + LAG;
      rx_in = (j < 8 || j == 12) ? 1'b0 : 1'b1;
      step();
      e = (k + 1) % 8;
      checkOutput("glitch_valid", k, 32'(samp_valid), (e == 6) ? 32'd1 : 32'd0);
      if (e == 6) checkOutput("glitch_sampled", k, 32'(sampled_bit), ((k + 1) < 8) ? 32'd0 : 32'd1);
    end

    $display("[TB] dat_samp_en dropped mid-window");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd8);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd8);
    for (int k = 0; k < 16; k++) begin
      dat_samp_en = (k == 4) ? 1'b0 : 1'b1;
      step();
      checkOutput("drop_valid", k, 32'(samp_valid), ((k + 1) == 14) ? 32'd1 : 32'd0);
      if ((k + 1) == 6) checkOutput("drop_hold", k, 32'(sampled_bit), 32'd1);
      if ((k + 1) == 14) checkOutput("drop_next_bit", k, 32'(sampled_bit), 32'd0);
    end

    $display("[TB] prescale change while enabled is ignored");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd32);
    for (int k = 0; k < 16; k++) begin
      step();
      e = (k + 1) % 8;
      checkOutput("frozen_edge", k, 32'(edge_cnt), 32'(e));
      checkOutput("frozen_valid", k, 32'(samp_valid), (e == 6) ? 32'd1 : 32'd0);
    end
    checkOutput("frozen_sampled", 16, 32'(sampled_bit), 32'd1);
    enable = 1'b0;
    step();
    checkOutput("idle_edge", 0, 32'(edge_cnt), 32'd0);
    checkOutput("idle_bit", 0, 32'(bit_cnt), 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 34; k++) begin
      j = k + LAG;
      rx_in = (j == 15 || j == 16) ? 1'b0 : 1'b1;
      step();
      checkOutput("x32_edge", k, 32'(edge_cnt), 32'((k + 1) % 32));
      checkOutput("x32_bit", k, 32'(bit_cnt), 32'((k + 1) / 32));
      checkOutput("x32_valid", k, 32'(samp_valid), ((k + 1) == 18) ? 32'd1 : 32'd0);
      if ((k + 1) == 18) checkOutput("x32_sampled", k, 32'(sampled_bit), 32'd0);
    end

    $display("[TB] illegal prescale 12 falls back to x8");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd12);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd12);
    for (int k = 0; k < 10; k++) begin
      j = k + LAG;
      rx_in = (j >= 3 && j <= 5) ? 1'b1 : 1'b0;
      step();
      e = (k + 1) % 8;
      checkOutput("ill_edge", k, 32'(edge_cnt), 32'(e));
      checkOutput("ill_bit", k, 32'(bit_cnt), 32'((k + 1) / 8));
      checkOutput("ill_valid", k, 32'(samp_valid), ((k + 1) == 6) ? 32'd1 : 32'd0);
      if ((k + 1) == 6) checkOutput("ill_sampled", k, 32'(sampled_bit), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_run, fail_count);
    $finish;
  end

endmodule
